// File: rtl/word_memory_pkg.sv
// word_memory_pkg: shared widths and FSM state encoding for the word memory
package word_memory_pkg;
  localparam int DEF_DW    = 8;
  localparam int DEF_AW    = 6;
  localparam int DEF_DEPTH = 64;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    CLEAR  = 2'd2,
    RESP   = 2'd3
  } state_t;
endpackage

// File: rtl/word_memory_word.sv
// mem_word: one storage word with async clear and load enable
module mem_word #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          Cl,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  // hold the word, loading d when enabled
  always_ff @(posedge clk or posedge Cl)
    if (Cl) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/word_memory.sv
// word_memory: req/ack word store with sequenced bulk clear
module word_memory
  import word_memory_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int AW    = DEF_AW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic          clk,
  input  logic          Cl,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] Din,
  input  logic          clr_all,
  output logic          ack,
  output logic          busy,
  output logic [DW-1:0] Dout
);
  state_t        state, next_state;
  logic [AW-1:0] addr_q, ptr;
  logic          we_q;
  logic [DW-1:0] din_q;
  logic [DW-1:0] words [DEPTH];
  logic          take_req, take_clr, in_clear;
  assign take_clr = (state == IDLE) && clr_all;
  assign take_req = (state == IDLE) && !clr_all && req;
  assign in_clear = (state == CLEAR);
  // state register
  always_ff @(posedge clk or posedge Cl)
    if (Cl) state <= IDLE;
    else state <= next_state;
  // next state: clear beats a simultaneous request, clear ends after the last word
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    next_state = clr_all ? CLEAR : req ? ACCESS : IDLE;
      ACCESS:  next_state = RESP;
      CLEAR:   next_state = (ptr == AW'(DEPTH - 1)) ? RESP : CLEAR;
      default: next_state = IDLE;
    endcase
  end
  // capture the request so the requester may drop it after sampling
  always_ff @(posedge clk or posedge Cl)
    if (Cl) begin
      addr_q <= '0;
      we_q   <= 1'b0;
      din_q  <= '0;
    end else if (take_req) begin
      addr_q <= addr;
      we_q   <= we;
      din_q  <= Din;
    end
  // clear pointer walks every word once; its wrap back to zero is harmless
  always_ff @(posedge clk or posedge Cl)
    if (Cl) ptr <= '0;
    else if (take_clr) ptr <= '0;
    else if (in_clear) ptr <= ptr + 1'b1;
  // status flags follow the state being entered so they line up with it
  always_ff @(posedge clk or posedge Cl)
    if (Cl) begin
      ack  <= 1'b0;
      busy <= 1'b0;
    end else begin
      ack  <= (next_state == RESP);
      busy <= (next_state != IDLE);
    end
  // read port: Dout keeps the last read word
  always_ff @(posedge clk or posedge Cl)
    if (Cl) Dout <= '0;
    else if (state == ACCESS && !we_q) Dout <= words[addr_q];
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic en;
    assign en = (state == ACCESS && we_q && addr_q == AW'(i)) || (in_clear && ptr == AW'(i));
    mem_word #(.DW(DW)) u_word (
      .clk (clk),
      .Cl  (Cl),
      .en  (en),
      .d   (in_clear ? '0 : din_q),
      .q   (words[i])
    );
  end
endmodule
